// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// requester port ids.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the data-memory arbiter.
// Build option DMEM_ARB_RR_EN: round-robin on conflict (keeps a one-bit
// pointer of the last issued port); undefined: port 0 always wins.
// The pointer lives here so that every trace of the option stays in this
// one module; the selection itself is purely combinational.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output logic       winner
);

`ifdef DMEM_ARB_RR_EN
  logic last_r;

  // Round-robin pointer: remembers the port issued on each IDLE->ISSUE step
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_r <= PORT_DBG;
    end else if (take) begin
      last_r <= winner;
    end
  end

  // On conflict the port that was not served last wins
  always_comb begin
    valid  = req[0] | req[1];
    winner = PORT_CPU;
    if (req == 2'b11) begin
      winner = ~last_r;
    end else if (req[1]) begin
      winner = PORT_DBG;
    end else begin
      winner = PORT_CPU;
    end
  end
`else
  // No pointer in fixed-priority mode, so these inputs carry no information
  logic unused_pick_s;
  assign unused_pick_s = clk ^ reset ^ take;

  // Fixed priority: the CPU port wins any conflict
  always_comb begin
    valid  = req[0] | req[1];
    winner = PORT_CPU;
    if (req[0]) begin
      winner = PORT_CPU;
    end else if (req[1]) begin
      winner = PORT_DBG;
    end else begin
      winner = PORT_CPU;
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single synchronous-read data memory.
// Port 0 is the CPU load/store port, port 1 the debug/loader port.
// IDLE latches the arbitration winner, ISSUE drives the memory strobe and
// the grant, RESP returns read data. Memory-side outputs come only from
// state and latched registers, never directly from the request inputs.
// Build option DMEM_ARB_RR_EN selects round-robin arbitration (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              owner_r;
  logic              we_r;
  logic [ADDR_W-3:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              pick_valid_s;
  logic              pick_winner_s;
  logic              take_s;
  logic              p0_rd_inflight_s;

  // Byte-lane bits are dropped on purpose: accesses are whole words
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^{p0_addr[1:0], p1_addr[1:0]};

  assign take_s = (state_r == ST_IDLE) && pick_valid_s;

  dmem_arb_pick u_pick (
    .clk    (clk),
    .reset  (reset),
    .req    ({p1_req, p0_req}),
    .take   (take_s),
    .valid  (pick_valid_s),
    .winner (pick_winner_s)
  );

  // State register plus latch of the winning request's fields
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      owner_r <= PORT_CPU;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (take_s) begin
        owner_r <= pick_winner_s;
        we_r    <= pick_winner_s ? p1_we : p0_we;
        addr_r  <= pick_winner_s ? p1_addr[ADDR_W-1:2] : p0_addr[ADDR_W-1:2];
        wdata_r <= pick_winner_s ? p1_wdata : p0_wdata;
      end
    end
  end

  // Next state and state-decoded strobes
  always_comb begin
    state_nxt_s = state_r;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    p0_rvalid   = 1'b0;
    p1_rvalid   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        mem_en = 1'b1;
        mem_we = we_r;
        p0_gnt = (owner_r == PORT_CPU);
        p1_gnt = (owner_r == PORT_DBG);
        if (we_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      ST_RESP: begin
        p0_rvalid   = (owner_r == PORT_CPU);
        p1_rvalid   = (owner_r == PORT_DBG);
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // CPU stall: held from request until the write grant or the read data,
  // including the ISSUE cycle of a CPU read whose req has already dropped
  always_comb begin
    p0_rd_inflight_s = (state_r == ST_ISSUE) && (owner_r == PORT_CPU) && !we_r;
    stall = reset && (p0_req || p0_rd_inflight_s) && !p0_rvalid && !(p0_gnt && we_r);
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a small synchronous RAM stands in for
// DMEM, and a word-level reference memory plus simple arbitration rules
// supply every expected value.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        stall, mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] tb_mem [0:255];
  logic        mem_clear;
  logic [31:0] ref_mem [int];
  int          n_cmp = 0;
  int          n_err = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory (256 words)
  always @(posedge clk) begin
    if (!reset) begin
      mem_rdata <= '0;
      if (mem_clear) for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
      else mem_rdata <= tb_mem[mem_addr[7:0]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic apply_reset();
    reset = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One isolated access on one port; reports grant/data latencies in cycles
  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int gnt_lat, output int rv_lat,
                           output logic [29:0] g_addr, output logic g_we,
                           output logic [31:0] g_wdata, output logic [31:0] rdata);
    gnt_lat = -1; rv_lat = -1; g_addr = '0; g_we = 1'b0; g_wdata = '0; rdata = '0;
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    if (port) begin p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1; end
    else begin p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1; end
    for (int c = 1; c <= 20 && (we ? gnt_lat < 0 : rv_lat < 0); c++) begin
      @(negedge clk);
      if ((port ? p1_gnt : p0_gnt) && gnt_lat < 0) begin
        gnt_lat = c; g_addr = mem_addr; g_we = mem_we; g_wdata = mem_wdata;
        p0_req = 1'b0; p1_req = 1'b0;
      end
      if ((port ? p1_rvalid : p0_rvalid) && rv_lat < 0) begin
        rv_lat = c; rdata = port ? p1_rdata : p0_rdata;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic test_reset();
    mem_clear = 1'b1; reset = 1'b0;
    p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, stall, mem_en, mem_we} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 0000000",
               {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, stall, mem_en, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, p0_rdata} !== 94'b0) begin
      n_err++;
      $display("FAIL reset_data: mem_addr=%h mem_wdata=%h rdata=%h want all 0",
               mem_addr, mem_wdata, p0_rdata);
    end
    reset = 1'b1; mem_clear = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, stall, mem_en, mem_we} !== 7'b0) begin
        n_err++;
        $display("FAIL idle_outputs cycle %0d: got %b want 0000000", c,
                 {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, stall, mem_en, mem_we});
      end
    end
  endtask

  task automatic test_write_read();
    int gl, rl; logic [29:0] ga; logic gw; logic [31:0] gd, rd;
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, gl, rl, ga, gw, gd, rd);
    ref_mem[4] = 32'hDEADBEEF;
    n_cmp++; if (gl !== 1) begin n_err++; $display("FAIL wr_gnt_lat: got %0d want 1", gl); end
    n_cmp++; if (gw !== 1'b1) begin n_err++; $display("FAIL wr_mem_we: got %b want 1", gw); end
    n_cmp++; if (ga !== 30'd4) begin n_err++; $display("FAIL wr_mem_addr: got %0d want 4", ga); end
    n_cmp++; if (gd !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_mem_wdata: got %h want deadbeef", gd); end
    do_access(1'b0, 1'b0, 32'h10, 32'h0, gl, rl, ga, gw, gd, rd);
    n_cmp++; if (rl !== 2) begin n_err++; $display("FAIL rd_rvalid_lat: got %0d want 2", rl); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_addr_trunc();
    int gl, rl; logic [29:0] ga; logic gw; logic [31:0] gd, rd;
    do_access(1'b0, 1'b0, 32'h13, 32'h0, gl, rl, ga, gw, gd, rd);
    n_cmp++; if (ga !== 30'd4) begin n_err++; $display("FAIL trunc_addr: got %0d want 4", ga); end
    n_cmp++; if (rd !== ref_rd(4)) begin n_err++; $display("FAIL trunc_data: got %h want %h", rd, ref_rd(4)); end
  endtask

  task automatic test_random();
    int gl, rl; logic [29:0] ga; logic gw; logic [31:0] gd, rd;
    bit port, we; logic [31:0] addr, data; int w;
    for (int i = 0; i < 40; i++) begin
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      w    = int'($urandom_range(0, 31));
      addr = 32'(w * 4 + int'($urandom_range(0, 3)));
      data = $urandom;
      do_access(port, we, addr, data, gl, rl, ga, gw, gd, rd);
      n_cmp++;
      if (gl !== 1 || ga !== 30'(w) || gw !== we) begin
        n_err++;
        $display("FAIL rand_issue %0d: lat=%0d addr=%0d we=%b want lat=1 addr=%0d we=%b",
                 i, gl, ga, gw, w, we);
      end
      if (we) begin
        n_cmp++;
        if (gd !== data) begin n_err++; $display("FAIL rand_wdata %0d: got %h want %h", i, gd, data); end
        ref_mem[w] = data;
      end else begin
        n_cmp++;
        if (rl !== 2 || rd !== ref_rd(w)) begin
          n_err++;
          $display("FAIL rand_read %0d: lat=%0d data=%h want lat=2 data=%h", i, rl, rd, ref_rd(w));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, r, cyc; int exp_q[$]; int w;
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    p0_we = 1'b1; p0_addr = 32'h80; p0_wdata = $urandom; p0_req = 1'b1;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 30) begin
      @(negedge clk); cyc++;
      if (p0_gnt) begin
        n_cmp++;
        if (cyc !== 1 + 2 * k) begin n_err++; $display("FAIL b2b_wr_gnt %0d: cycle %0d want %0d", k, cyc, 1 + 2 * k); end
        ref_mem[int'(p0_addr >> 2)] = p0_wdata;
        k++;
        if (k < 3) begin p0_addr = 32'h80 + 32'(4 * k); p0_wdata = $urandom; end
        else p0_req = 1'b0;
      end
    end
    n_cmp++; if (k !== 3) begin n_err++; $display("FAIL b2b_wr_count: got %0d want 3", k); end
    p0_req = 1'b0;
    @(negedge clk);
    p0_we = 1'b0; p0_addr = 32'h80; p0_req = 1'b1;
    k = 0; r = 0; cyc = 0;
    while (r < 3 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (p0_gnt) begin
        n_cmp++;
        if (cyc !== 1 + 3 * k) begin n_err++; $display("FAIL b2b_rd_gnt %0d: cycle %0d want %0d", k, cyc, 1 + 3 * k); end
        exp_q.push_back(int'(p0_addr >> 2));
        k++;
        if (k < 3) p0_addr = 32'h80 + 32'(4 * k);
        else p0_req = 1'b0;
      end
      if (p0_rvalid && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        n_cmp++;
        if (cyc !== 2 + 3 * r || p0_rdata !== ref_rd(w)) begin
          n_err++;
          $display("FAIL b2b_rd_data %0d: cycle %0d data %h want cycle %0d data %h",
                   r, cyc, p0_rdata, 2 + 3 * r, ref_rd(w));
        end
        r++;
      end
    end
    n_cmp++; if (r !== 3) begin n_err++; $display("FAIL b2b_rd_count: got %0d want 3", r); end
    p0_req = 1'b0;
  endtask

  task automatic test_conflict();
    bit p0_act, p1_act, prev, exp_w, got; int ngr, p0_cnt, cyc;
    apply_reset();
    p0_we = 1'b0; p0_addr = 32'h100; p1_we = 1'b0; p1_addr = 32'h200;
    p0_req = 1'b1; p1_req = 1'b1;
    p0_act = 1'b1; p1_act = 1'b1; prev = 1'b1;
    ngr = 0; p0_cnt = 0; cyc = 0;
    while (ngr < 5 && cyc < 60) begin
      @(negedge clk); cyc++;
      n_cmp++;
      if (p0_gnt && p1_gnt) begin n_err++; $display("FAIL conflict_double_gnt: cycle %0d", cyc); end
      if (p0_gnt || p1_gnt) begin
        got = p1_gnt;
        if (p0_act && p1_act) exp_w = RR ? ~prev : 1'b0;
        else exp_w = p0_act ? 1'b0 : 1'b1;
        n_cmp++;
        if (got !== exp_w || cyc !== 1 + 3 * ngr) begin
          n_err++;
          $display("FAIL conflict_grant %0d: port %0d at cycle %0d want port %0d at cycle %0d",
                   ngr, got, cyc, exp_w, 1 + 3 * ngr);
        end
        prev = exp_w; ngr++;
        if (!got) begin
          p0_cnt++;
          if (p0_cnt == 3) begin p0_req = 1'b0; p0_act = 1'b0; end
        end
      end
    end
    n_cmp++; if (ngr !== 5) begin n_err++; $display("FAIL conflict_count: got %0d want 5", ngr); end
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall();
    bit done, p1_done, seen_rv; int cyc; logic [31:0] old;
    // p1 write raised one cycle ahead of the p0 read of the same word
    apply_reset();
    p1_we = 1'b1; p1_addr = 32'h40; p1_wdata = 32'h1234; p1_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (p1_gnt !== 1'b1) begin n_err++; $display("FAIL stall_a_p1_gnt: got %b want 1", p1_gnt); end
    p1_req = 1'b0; ref_mem[16] = 32'h1234;
    p0_we = 1'b0; p0_addr = 32'h40; p0_req = 1'b1;
    done = 1'b0; cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk); cyc++;
      if (p0_gnt) p0_req = 1'b0;
      n_cmp++;
      if (p0_rvalid) begin
        done = 1'b1;
        if (stall !== 1'b0 || p0_rdata !== 32'h1234) begin
          n_err++; $display("FAIL stall_a_resp: stall=%b data=%h want stall=0 data=00001234", stall, p0_rdata);
        end
      end else if (stall !== 1'b1) begin
        n_err++; $display("FAIL stall_a_wait cycle %0d: stall=%b want 1", cyc, stall);
      end
    end
    n_cmp++; if (!done) begin n_err++; $display("FAIL stall_a_timeout: no p0_rvalid"); end
    p0_req = 1'b0;
    // Simultaneous requests right after reset: p0 wins and reads the old word
    apply_reset();
    old = ref_rd(16);
    p1_we = 1'b1; p1_addr = 32'h40; p1_wdata = 32'h5678; p1_req = 1'b1;
    p0_we = 1'b0; p0_addr = 32'h40; p0_req = 1'b1;
    done = 1'b0; p1_done = 1'b0; seen_rv = 1'b0; cyc = 0;
    while (!(done && p1_done) && cyc < 20) begin
      @(negedge clk); cyc++;
      if (p0_gnt) p0_req = 1'b0;
      if (p1_gnt) begin p1_req = 1'b0; p1_done = 1'b1; ref_mem[16] = 32'h5678; end
      n_cmp++;
      if (stall !== !(seen_rv || p0_rvalid)) begin
        n_err++; $display("FAIL stall_b cycle %0d: stall=%b want %b", cyc, stall, !(seen_rv || p0_rvalid));
      end
      if (p0_rvalid) begin
        done = 1'b1; seen_rv = 1'b1;
        n_cmp++;
        if (p0_rdata !== old || p1_done) begin
          n_err++; $display("FAIL stall_b_data: data=%h p1_first=%b want data=%h p1_first=0", p0_rdata, p1_done, old);
        end
      end
    end
    n_cmp++; if (!(done && p1_done)) begin n_err++; $display("FAIL stall_b_timeout: rvalid=%b p1_gnt=%b", done, p1_done); end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic test_reset_midop();
    int gl, rl; logic [29:0] ga; logic gw; logic [31:0] gd, rd;
    p0_req = 1'b0; p1_req = 1'b0;
    @(negedge clk);
    p0_we = 1'b0; p0_addr = 32'h10; p0_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (p0_gnt !== 1'b1) begin n_err++; $display("FAIL midop_gnt: got %b want 1", p0_gnt); end
    reset = 1'b0; p0_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({p0_rvalid, p0_gnt, mem_en, stall} !== 4'b0) begin
      n_err++; $display("FAIL midop_abort: rvalid/gnt/mem_en/stall=%b want 0000", {p0_rvalid, p0_gnt, mem_en, stall});
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({p0_rvalid, p1_rvalid, mem_en} !== 3'b0) begin
        n_err++; $display("FAIL midop_quiet cycle %0d: rvalid0/rvalid1/mem_en=%b want 000", c, {p0_rvalid, p1_rvalid, mem_en});
      end
    end
    do_access(1'b0, 1'b0, 32'h10, 32'h0, gl, rl, ga, gw, gd, rd);
    n_cmp++;
    if (gl !== 1 || rl !== 2 || rd !== ref_rd(4)) begin
      n_err++; $display("FAIL midop_rerequest: gnt_lat=%0d rv_lat=%0d data=%h want 1 2 %h", gl, rl, rd, ref_rd(4));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_addr_trunc();
    test_random();
    test_back_to_back();
    test_conflict();
    test_stall();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
